// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: computes A - B - Bin one SLICE-bit group per clock,
// LSB group first. The registered results update only when the last group is
// processed, and done pulses for the following cycle.
module serial_subtractor #(
   parameter int WIDTH = 8,
   parameter int SLICE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             V,
   output logic             zero
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               borrow_q, borrow_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic               bout_q, bout_d;
   logic               v_q, v_d;
   logic               zero_q, zero_d;
   logic               done_q, done_d;

   logic [SLICE:0]       grp;
   logic [WIDTH+SLICE-1:0] cat;
   logic                 last;

   // Next-state and datapath: operands shift right, group differences shift into res from the top.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      d_d      = d_q;
      bout_d   = bout_q;
      v_d      = v_q;
      zero_d   = zero_q;
      done_d   = 1'b0;

      grp  = {1'b0, a_q[SLICE-1:0]} - {1'b0, b_q[SLICE-1:0]} - {{SLICE{1'b0}}, borrow_q};
      cat  = {grp[SLICE-1:0], res_q};
      last = (cnt_q == CW'(N - 1));

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d      = A;
               b_d      = B;
               borrow_d = Bin;
               cnt_d    = '0;
               res_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            a_d      = a_q >> SLICE;
            b_d      = b_q >> SLICE;
            borrow_d = grp[SLICE];
            res_d    = cat[WIDTH+SLICE-1:SLICE];
            cnt_d    = cnt_q + 1'b1;
            if (last) begin
               state_d = IDLE;
               done_d  = 1'b1;
               d_d     = res_d;
               bout_d  = grp[SLICE];
               // Sign-rule form of (borrow into MSB ^ borrow out of MSB); the two are equivalent.
               v_d     = (a_q[SLICE-1] ^ b_q[SLICE-1]) & (a_q[SLICE-1] ^ grp[SLICE-1]);
               zero_d  = (res_d == '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and data registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         d_q      <= '0;
         bout_q   <= 1'b0;
         v_q      <= 1'b0;
         zero_q   <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         d_q      <= d_d;
         bout_q   <= bout_d;
         v_q      <= v_d;
         zero_q   <= zero_d;
         done_q   <= done_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign D    = d_q;
   assign Bout = bout_q;
   assign V    = v_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a SLICE=1 and a SLICE=4 instance, an
// arithmetic reference model checked every cycle, and directed vectors
// with hand-computed literal expectations.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n, start, start4, Bin;
   logic [7:0] A, B;

   logic       busy1, done1, Bout1, V1, zero1;
   logic [7:0] D1;
   logic       busy4, done4, Bout4, V4, zero4;
   logic [7:0] D4;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state, index 0 = SLICE 1, index 1 = SLICE 4.
   logic       m_busy [2];
   int         m_left [2];
   logic       m_done [2];
   logic [7:0] m_D    [2];
   logic       m_Bout [2];
   logic       m_V    [2];
   logic       m_zero [2];
   logic [7:0] p_D    [2];
   logic       p_Bout [2];
   logic       p_V    [2];
   logic       p_zero [2];

   serial_subtractor #(.WIDTH(8), .SLICE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
      .busy(busy1), .done(done1), .D(D1), .Bout(Bout1), .V(V1), .zero(zero1)
   );

   serial_subtractor #(.WIDTH(8), .SLICE(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .A(A), .B(B), .Bin(Bin),
      .busy(busy4), .done(done4), .D(D4), .Bout(Bout4), .V(V4), .zero(zero4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic calc(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [7:0] d, output logic bo, output logic v, output logic z);
      int ud, sd;
      ud = int'(a) - int'(b) - int'(bin);
      sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
      d  = 8'(ud);
      bo = (ud < 0);
      v  = (sd < -128) || (sd > 127);
      z  = (d == 8'h00);
   endtask

   task automatic model_edge(input int k, input logic st);
      int groups;
      groups = (k == 0) ? 8 : 2;
      if (!rst_n) begin
         m_busy[k] = 1'b0; m_left[k] = 0; m_done[k] = 1'b0;
         m_D[k] = 8'h00; m_Bout[k] = 1'b0; m_V[k] = 1'b0; m_zero[k] = 1'b1;
      end else begin
         m_done[k] = 1'b0;
         if (m_busy[k]) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
               m_busy[k] = 1'b0;
               m_done[k] = 1'b1;
               m_D[k] = p_D[k]; m_Bout[k] = p_Bout[k]; m_V[k] = p_V[k]; m_zero[k] = p_zero[k];
            end
         end else if (st) begin
            calc(A, B, Bin, p_D[k], p_Bout[k], p_V[k], p_zero[k]);
            m_busy[k] = 1'b1;
            m_left[k] = groups;
         end
      end
   endtask

   // One clock: advance the model at the edge, compare both DUTs mid-cycle.
   task automatic tick();
      @(posedge clk);
      model_edge(0, start);
      model_edge(1, start4);
      @(negedge clk);
      chk("busy1", 32'(busy1), 32'(m_busy[0]));
      chk("done1", 32'(done1), 32'(m_done[0]));
      chk("D1",    32'(D1),    32'(m_D[0]));
      chk("Bout1", 32'(Bout1), 32'(m_Bout[0]));
      chk("V1",    32'(V1),    32'(m_V[0]));
      chk("zero1", 32'(zero1), 32'(m_zero[0]));
      chk("busy4", 32'(busy4), 32'(m_busy[1]));
      chk("done4", 32'(done4), 32'(m_done[1]));
      chk("D4",    32'(D4),    32'(m_D[1]));
      chk("Bout4", 32'(Bout4), 32'(m_Bout[1]));
      chk("V4",    32'(V4),    32'(m_V[1]));
      chk("zero4", 32'(zero4), 32'(m_zero[1]));
   endtask

   // Start one operation on the chosen instance; lat = ticks after the start edge until done.
   task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic bin,
                         output int lat);
      logic d;
      A = a; B = b; Bin = bin;
      if (k == 0) start = 1'b1; else start4 = 1'b1;
      tick();
      start = 1'b0; start4 = 1'b0;
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         d = (k == 0) ? done1 : done4;
         if (d) begin
            lat = i;
            break;
         end
      end
   endtask

   initial begin
      int lat, bc, dcount, nd;
      int dt [4];

      rst_n = 1'b0; start = 1'b0; start4 = 1'b0; A = 8'h00; B = 8'h00; Bin = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 1'b0; m_left[k] = 0; m_done[k] = 1'b0; m_D[k] = 8'h00;
         m_Bout[k] = 1'b0; m_V[k] = 1'b0; m_zero[k] = 1'b1;
         p_D[k] = 8'h00; p_Bout[k] = 1'b0; p_V[k] = 1'b0; p_zero[k] = 1'b0;
      end
      @(negedge clk);
      tick(); tick();
      chk("rst busy", 32'(busy1), 32'd0);
      chk("rst D",    32'(D1),    32'h00);
      chk("rst zero", 32'(zero1), 32'd1);
      rst_n = 1'b1;
      tick();

      // 5 - 3
      run_op(0, 8'h05, 8'h03, 1'b0, lat);
      chk("lat 5-3",  32'(lat),   32'd8);
      chk("D 5-3",    32'(D1),    32'h02);
      chk("Bout 5-3", 32'(Bout1), 32'd0);
      chk("V 5-3",    32'(V1),    32'd0);
      chk("zero 5-3", 32'(zero1), 32'd0);
      tick();
      chk("done width", 32'(done1), 32'd0);

      // 0 - 1, then 0x80 - 1
      run_op(0, 8'h00, 8'h01, 1'b0, lat);
      chk("D 0-1",    32'(D1),    32'hFF);
      chk("Bout 0-1", 32'(Bout1), 32'd1);
      chk("V 0-1",    32'(V1),    32'd0);
      tick();
      run_op(0, 8'h80, 8'h01, 1'b0, lat);
      chk("D 80-1",    32'(D1),    32'h7F);
      chk("Bout 80-1", 32'(Bout1), 32'd0);
      chk("V 80-1",    32'(V1),    32'd1);
      tick();

      // 0x10 - 0x0F - 1 with a start pulse and operand changes mid-run
      A = 8'h10; B = 8'h0F; Bin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      bc = int'(busy1);
      dcount = -1;
      for (int i = 1; i <= 12; i++) begin
         if (i == 3) begin
            start = 1'b1; A = 8'hFF; B = 8'h00; Bin = 1'b0;
         end else begin
            start = 1'b0;
         end
         tick();
         if (busy1) bc++;
         if (done1 && dcount < 0) dcount = i;
      end
      chk("busy cycles", 32'(bc),     32'd8);
      chk("lat 10-0F",   32'(dcount), 32'd8);
      chk("D 10-0F-1",   32'(D1),     32'h00);
      chk("zero 10-0F",  32'(zero1),  32'd1);
      chk("Bout 10-0F",  32'(Bout1),  32'd0);

      // reset mid-operation, start held during reset
      nd = 0;
      A = 8'h05; B = 8'h03; Bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done1) nd++;
      end
      rst_n = 1'b0; start = 1'b1;
      tick();
      if (done1) nd++;
      chk("abort busy", 32'(busy1), 32'd0);
      chk("abort D",    32'(D1),    32'h00);
      chk("abort zero", 32'(zero1), 32'd1);
      tick();
      chk("start in rst", 32'(busy1), 32'd0);
      rst_n = 1'b1; start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done1) nd++;
      end
      chk("abort no done", 32'(nd), 32'd0);
      run_op(0, 8'h09, 8'h0A, 1'b0, lat);
      chk("lat 9-A",  32'(lat),   32'd8);
      chk("D 9-A",    32'(D1),    32'hFF);
      chk("Bout 9-A", 32'(Bout1), 32'd1);
      tick();

      // back-to-back with start held high
      nd = 0;
      A = 8'h20; B = 8'h01; Bin = 1'b0; start = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (done1 && nd < 4) begin
            dt[nd] = i;
            nd++;
         end
      end
      start = 1'b0;
      chk("b2b count", 32'(nd >= 3), 32'd1);
      chk("b2b gap1",  32'(dt[1] - dt[0]), 32'd9);
      chk("b2b gap2",  32'(dt[2] - dt[1]), 32'd9);
      chk("b2b D",     32'(D1), 32'h1F);
      for (int i = 0; i < 12; i++) tick();

      // SLICE=4 instance
      run_op(1, 8'h34, 8'h56, 1'b0, lat);
      chk("lat s4",  32'(lat),   32'd2);
      chk("D s4",    32'(D4),    32'hDE);
      chk("Bout s4", 32'(Bout4), 32'd1);
      chk("V s4",    32'(V4),    32'd0);
      tick();
      run_op(1, 8'h80, 8'h01, 1'b0, lat);
      chk("D s4 80-1", 32'(D4), 32'h7F);
      chk("V s4 80-1", 32'(V4), 32'd1);
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, is the operand and result width in bits; WIDTH SHALL be >= 2.
REQ-002 Parameter SLICE, default 1, is the number of bits processed per cycle; SLICE SHALL divide WIDTH exactly, and N = WIDTH/SLICE.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 Port start, input, 1 bit: request to begin an operation.
REQ-006 Port A, input, WIDTH bits: minuend, sampled only when start is accepted.
REQ-007 Port B, input, WIDTH bits: subtrahend, sampled only when start is accepted.
REQ-008 Port Bin, input, 1 bit: borrow-in, sampled only when start is accepted.
REQ-009 Port busy, output, 1 bit: high while an operation is in progress.
REQ-010 Port done, output, 1 bit: one-cycle pulse marking that the result is valid.
REQ-011 Port D, output, WIDTH bits: difference.
REQ-012 Port Bout, output, 1 bit: borrow-out.
REQ-013 Port V, output, 1 bit: signed (two's-complement) overflow.
REQ-014 Port zero, output, 1 bit: high when D == 0.

Function
REQ-015 The FSM SHALL have two states, IDLE and RUN; busy SHALL be 1 exactly when the state is RUN.
REQ-016 In IDLE, start=1 at an edge SHALL:
- latch A, B and Bin;
- clear the slice counter;
- enter RUN.
REQ-017 In RUN, at each edge one SLICE-bit group SHALL be processed, LSB group first, using the internal borrow chain. The borrow of group i feeds group i+1; the latched Bin feeds group 0.
REQ-018 At the edge that processes group N-1:
- state SHALL return to IDLE;
- D, Bout, V and zero SHALL update;
- done SHALL be 1 for exactly the following cycle.
REQ-019 Latency: start accepted at edge e0 -> done high after edge eN -> done low after edge eN+1.
REQ-020 Results SHALL satisfy:
- D = (A - B - Bin) mod 2^WIDTH;
- Bout = 1 iff A < B + Bin (unsigned);
- V = borrow into MSB XOR borrow out of MSB.
REQ-021 D, Bout, V and zero SHALL hold their previous values during RUN; partial results SHALL NOT appear on the outputs.
REQ-022 start while busy=1 SHALL be ignored; A, B and Bin changes during RUN SHALL NOT affect the result.
REQ-023 start=1 in the cycle where done=1 (state IDLE) SHALL be accepted; back-to-back operations SHALL therefore sustain one result per N+1 cycles.
REQ-024 Results SHALL hold until the next completed operation.

Reset
REQ-025 rst_n=0 at an edge SHALL, regardless of state:
- set state to IDLE;
- set busy=0, done=0, D=0, Bout=0, V=0, zero=1;
- clear the counter and internal operand registers.
REQ-026 Reset mid-operation SHALL abort it without a done pulse; start SHALL be ignored while rst_n=0.
REQ-027 The first start after rst_n returns high SHALL be accepted normally.

Verification (WIDTH=8, SLICE=1 unless stated)
REQ-028 A=0x05, B=0x03, Bin=0 -> done 8 cycles after the start edge; D=0x02, Bout=0, V=0, zero=0.
REQ-029 A=0x00, B=0x01, Bin=0 -> D=0xFF, Bout=1, V=0; then A=0x80, B=0x01 -> D=0x7F, Bout=0, V=1.
REQ-030 A=0x10, B=0x0F, Bin=1 -> D=0x00, zero=1, Bout=0; busy stays high for 8 cycles, and a start pulse at cycle 3 is ignored.
REQ-031 Start A=0x05, B=0x03; assert rst_n=0 after 4 cycles -> busy=0, D=0x00, zero=1, no done pulse. Then A=0x09, B=0x0A, Bin=0 -> D=0xFF, Bout=1.
REQ-032 Back-to-back: start held high through done -> second operation is accepted in the done cycle; each result is correct and the done pulses are 9 cycles apart.
REQ-033 SLICE=4: A=0x34, B=0x56, Bin=0 -> done 2 cycles after the start edge; D=0xDE, Bout=1, V=0.
